// File: rtl/main_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : main_ctrl_fsm_if
//  Description : Bundle of the instruction fields, status flags and control
//                strobes that pass between the main control FSM and the
//                multicycle MIPS datapath.
//                  master : the control FSM (consumes opcode/funct/zero/
//                           mem_ready, drives every enable and select)
//                  slave  : the datapath side (the mirror image)
//  Revision    : 1.0 - initial release
// ============================================================================
interface main_ctrl_fsm_if;
  logic [5:0] opcode;     // IR[31:26]
  logic [5:0] funct;      // IR[5:0]
  logic       zero;       // ALU zero flag
  logic       mem_ready;  // memory has completed the current access

  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : main_ctrl_fsm
//  Description : Moore main control unit of the multicycle MIPS datapath.
//                Sequences lw, sw, R-type (incl. jr), beq, addi and j
//                through fetch/decode/execute/memory/writeback steps and
//                stalls FETCH, MEMRD and MEMWR on the mem_ready handshake.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous, active-high reset (forces outputs 0)
//                bus  - main_ctrl_fsm_if.master: opcode, funct, zero,
//                       mem_ready in; datapath enables/selects, PCEn,
//                       illegal and debug state out
//  Parameters  : MEM_WAIT_EN - 1: wait for mem_ready, 0: treat it as 1
//  Revision    : 1.0 - initial release
// ============================================================================
module main_ctrl_fsm #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  main_ctrl_fsm_if.master bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_FN_JR    = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JREXEC   = 4'd12
  } state_t;

  state_t     r_state;

  logic       w_ready;
  logic       w_op_legal;
  logic       w_iord;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic [1:0] w_pcsrc;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_illegal;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_ready = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

  assign w_op_legal = (bus.opcode == c_OP_LW)    || (bus.opcode == c_OP_SW)  ||
                      (bus.opcode == c_OP_RTYPE) || (bus.opcode == c_OP_BEQ) ||
                      (bus.opcode == c_OP_ADDI)  || (bus.opcode == c_OP_J);

  // --------------------------------------------------------------------------
  // State register and next-state selection
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            c_OP_LW, c_OP_SW: r_state <= S_MEMADR;
            c_OP_RTYPE:       r_state <= (bus.funct == c_FN_JR) ? S_JREXEC : S_EXECUTE;
            c_OP_BEQ:         r_state <= S_BRANCH;
            c_OP_ADDI:        r_state <= S_ADDIEXEC;
            c_OP_J:           r_state <= S_JUMP;
            default:          r_state <= S_FETCH;
          endcase
        end
        // Only lw and sw reach MEMADR, so the sw test alone picks the path.
        S_MEMADR:   r_state <= (bus.opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:    if (w_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWR:    if (w_ready) r_state <= S_FETCH;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        S_ADDIWB:   r_state <= S_FETCH;
        S_JUMP:     r_state <= S_FETCH;
        S_JREXEC:   r_state <= S_FETCH;
        default:    r_state <= S_FETCH;  // unused codes recover to FETCH
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Moore output decode (FETCH also looks at mem_ready, BRANCH at zero)
  // --------------------------------------------------------------------------
  always_comb begin
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluop    = 2'b00;
    w_pcsrc    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;        // PC + 4
        w_irwrite = w_ready;
        w_pcwrite = w_ready;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;        // branch target precompute
        w_illegal = ~w_op_legal;
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_JREXEC: begin
        // ALU control treats funct 0x08 as ADD, so the PC takes rs + $0.
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Outputs are held low for as long as reset is asserted, so an abandoned
  // instruction cannot issue a strobe in the reset cycle itself.
  assign bus.IorD     = rst ? 1'b0  : w_iord;
  assign bus.MemWrite = rst ? 1'b0  : w_memwrite;
  assign bus.IRWrite  = rst ? 1'b0  : w_irwrite;
  assign bus.RegDst   = rst ? 1'b0  : w_regdst;
  assign bus.MemtoReg = rst ? 1'b0  : w_memtoreg;
  assign bus.RegWrite = rst ? 1'b0  : w_regwrite;
  assign bus.ALUSrcA  = rst ? 1'b0  : w_alusrca;
  assign bus.ALUSrcB  = rst ? 2'b00 : w_alusrcb;
  assign bus.ALUOp    = rst ? 2'b00 : w_aluop;
  assign bus.PCSrc    = rst ? 2'b00 : w_pcsrc;
  assign bus.PCEn     = rst ? 1'b0  : (w_pcwrite | (w_branch & bus.zero));
  assign bus.illegal  = rst ? 1'b0  : w_illegal;
  assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_ctrl_fsm
//  Description : Self-checking bench for main_ctrl_fsm. A route-table model
//                (the state path each instruction class walks, plus the
//                per-state control word) predicts state and outputs on every
//                cycle; directed instructions pin the model with literal
//                state sequences, cycle counts and strobe counts, followed
//                by randomized instructions, stalls and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_ctrl_fsm;

  logic clk;
  logic rst;

  main_ctrl_fsm_if bus ();

  main_ctrl_fsm #(.MEM_WAIT_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: the route of the current instruction and the position on it.
  int m_path [0:5];
  int m_len;
  int m_idx;
  bit m_done;

  bit cmp_en = 0;
  bit rec_en = 0;
  int obs_st[$];
  int cnt_regwr, cnt_memwr, cnt_pcen, cnt_ill, cnt_m2r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_legal(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
  endfunction

  // Route of each instruction class through the state codes.
  task automatic build_path(input logic [5:0] op, input logic [5:0] fn);
    m_path[0] = 0;
    m_path[1] = 1;
    m_len     = 2;
    case (op)
      6'b100011: begin m_path[2] = 2; m_path[3] = 3; m_path[4] = 4; m_len = 5; end
      6'b101011: begin m_path[2] = 2; m_path[3] = 5; m_len = 4; end
      6'b000000: begin
        if (fn == 6'h08) begin m_path[2] = 12; m_len = 3; end
        else begin m_path[2] = 6; m_path[3] = 7; m_len = 4; end
      end
      6'b000100: begin m_path[2] = 8; m_len = 3; end
      6'b001000: begin m_path[2] = 9; m_path[3] = 10; m_len = 4; end
      6'b000010: begin m_path[2] = 11; m_len = 3; end
      default:   m_len = 2;
    endcase
  endtask

  // Control word {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
  //               ALUSrcB,ALUOp,PCSrc,PCEn,illegal} required in a state.
  function automatic logic [14:0] exp_word(input int st, input logic mr,
                                           input logic z, input logic [5:0] op);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen, ill;
    logic [1:0] sb, aop, pcs;
    {iord, mw, irw, rd, m2r, rw, sa, pcen, ill} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin irw = mr; pcen = mr; sb = 2'b01; end
      1:  begin sb = 2'b11; ill = !op_legal(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      12: begin sa = 1; aop = 2'b10; pcen = 1; end
      default: begin end
    endcase
    return {iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, pcen, ill};
  endfunction

  // Single compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      int         est;
      logic [14:0] ew, aw;
      est = rst ? 0 : m_path[m_idx];
      ew  = rst ? 15'd0 : exp_word(est, bus.mem_ready, bus.zero, bus.opcode);
      aw  = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
             bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc,
             bus.PCEn, bus.illegal};
      check("state", {28'd0, bus.state}, est);
      check("ctrl_word", {17'd0, aw}, {17'd0, ew});
      if (rec_en) begin
        obs_st.push_back(int'(bus.state));
        cnt_regwr += int'(bus.RegWrite);
        cnt_memwr += int'(bus.MemWrite);
        cnt_pcen  += int'(bus.PCEn);
        cnt_ill   += int'(bus.illegal);
        cnt_m2r   += int'(bus.MemtoReg);
      end
    end
  end

  task automatic advance();
    int cur;
    cur = m_path[m_idx];
    if ((cur == 0 || cur == 3 || cur == 5) && !bus.mem_ready) return;
    m_idx++;
    if (m_idx >= m_len) begin
      m_idx  = 0;
      m_done = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) advance();
    #1;
  endtask

  task automatic go_idle();
    m_len     = 1;
    m_path[0] = 0;
    m_idx     = 0;
  endtask

  // Runs one instruction from the start of its FETCH to the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit rnd,
                           input int stall_st, input int stall_n, input logic z,
                           output int ncyc);
    int left;
    left = stall_n;
    ncyc = 0;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    build_path(op, fn);
    m_idx  = 0;
    m_done = 0;
    while (!m_done && ncyc < 64) begin
      if (rnd) begin
        bus.mem_ready = ($urandom_range(0, 3) != 0);
        bus.zero      = 1'($urandom_range(0, 1));
      end else if (m_path[m_idx] == stall_st && left > 0) begin
        bus.mem_ready = 1'b0;
        left--;
      end else begin
        bus.mem_ready = 1'b1;
      end
      if (rnd && $urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        go_idle();
        tick();
        rst    = 1'b0;
        m_done = 1;
      end else begin
        tick();
      end
      ncyc++;
    end
    if (!m_done) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: instruction op=%0h did not complete in %0d cycles", op, ncyc);
    end
  endtask

  task automatic rec_start();
    obs_st.delete();
    cnt_regwr = 0; cnt_memwr = 0; cnt_pcen = 0; cnt_ill = 0; cnt_m2r = 0;
    rec_en = 1;
  endtask

  // Compares the recorded state sequence against a hex-digit string.
  task automatic check_seq(input string name, input string exp);
    string got;
    got = "";
    foreach (obs_st[i]) got = {got, $sformatf("%0h", obs_st[i])};
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got sequence %s, expected %s", name, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] op, fn;
    int k;

    rst = 1'b1;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
    bus.mem_ready = 1'b1;   // IRWrite would rise here if reset did not gate it
    go_idle();
    m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1;
    check("reset_state", {28'd0, bus.state}, 0);
    check("reset_irwrite", {31'd0, bus.IRWrite}, 0);
    check("reset_alusrcb", {30'd0, bus.ALUSrcB}, 0);
    tick();
    bus.mem_ready = 1'b0;
    rst = 1'b0;

    // lw with a 2-cycle stall in MEMRD
    rec_start();
    run_instr(6'b100011, 6'h00, 0, 3, 2, 1'b0, n);
    rec_en = 0;
    check_seq("lw_seq", "0123334");
    check("lw_cycles", n, 7);
    check("lw_regwrite_cnt", cnt_regwr, 1);
    check("lw_memtoreg_cnt", cnt_m2r, 1);

    // R-type slt
    rec_start();
    run_instr(6'b000000, 6'h2A, 0, -1, 0, 1'b0, n);
    rec_en = 0;
    check_seq("slt_seq", "0167");
    check("slt_regwrite_cnt", cnt_regwr, 1);

    // jr
    rec_start();
    run_instr(6'b000000, 6'h08, 0, -1, 0, 1'b0, n);
    rec_en = 0;
    check_seq("jr_seq", "01c");
    check("jr_pcen_cnt", cnt_pcen, 2);

    // beq taken / not taken
    rec_start();
    run_instr(6'b000100, 6'h00, 0, -1, 0, 1'b1, n);
    rec_en = 0;
    check_seq("beq_t_seq", "018");
    check("beq_t_pcen_cnt", cnt_pcen, 2);
    rec_start();
    run_instr(6'b000100, 6'h00, 0, -1, 0, 1'b0, n);
    rec_en = 0;
    check_seq("beq_nt_seq", "018");
    check("beq_nt_pcen_cnt", cnt_pcen, 1);

    // sw with a 1-cycle stall in MEMWR
    rec_start();
    run_instr(6'b101011, 6'h00, 0, 5, 1, 1'b0, n);
    rec_en = 0;
    check_seq("sw_seq", "01255");
    check("sw_memwrite_cnt", cnt_memwr, 2);

    // addi and j
    rec_start();
    run_instr(6'b001000, 6'h00, 0, -1, 0, 1'b0, n);
    rec_en = 0;
    check_seq("addi_seq", "019a");
    rec_start();
    run_instr(6'b000010, 6'h00, 0, -1, 0, 1'b0, n);
    rec_en = 0;
    check_seq("j_seq", "01b");

    // illegal opcode
    rec_start();
    run_instr(6'b111111, 6'h00, 0, -1, 0, 1'b0, n);
    rec_en = 0;
    check_seq("illegal_seq", "01");
    check("illegal_pulse_cnt", cnt_ill, 1);
    check("illegal_strobes", cnt_regwr + cnt_memwr, 0);

    // reset in the middle of a stalled sw
    bus.opcode = 6'b101011;
    bus.funct  = 6'h00;
    build_path(6'b101011, 6'h00);
    m_idx = 0; m_done = 0;
    bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    #2;
    check("memwr_before_rst", {31'd0, bus.MemWrite}, 1);
    rst = 1'b1;
    go_idle();
    #1;
    check("rst_memwrite", {31'd0, bus.MemWrite}, 0);
    check("rst_iord", {31'd0, bus.IorD}, 0);
    check("rst_state", {28'd0, bus.state}, 0);
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("post_rst_irwrite", {31'd0, bus.IRWrite}, 1);
    check("post_rst_pcen", {31'd0, bus.PCEn}, 1);
    run_instr(6'b001000, 6'h00, 0, -1, 0, 1'b0, n);
    check("post_rst_addi_cycles", n, 4);

    // randomized instruction stream with stalls, stray mem_ready and resets
    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(0, 9);
      fn = 6'($urandom_range(0, 63));
      case (k)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: begin op = 6'b000000; fn = 6'h08; end
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000010;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, 1, -1, 0, 1'b0, n);
    end

    bus.mem_ready = 1'b0;
    go_idle();
    repeat (2) tick();
    cmp_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
